// File: rtl/pong_pkg.sv
// Shared definitions for the pong game controller: state encodings,
// screen borders, score width and small arithmetic helpers.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SERVE    = 3'd1,
        ST_PLAY     = 3'd2,
        ST_POINT    = 3'd3,
        ST_GAMEOVER = 3'd4
    } state_t;

    localparam int RIGHT_BORDER  = 799;
    localparam int BOTTOM_BORDER = 599;
    localparam int SCORE_W       = 4;

    // Score increment that sticks at the maximum value.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        return (s == {SCORE_W{1'b1}}) ? s : s + 1'b1;
    endfunction

    // Vertical overlap between the ball and a paddle, in 12-bit signed space.
    function automatic logic overlap(input logic signed [11:0] by,
                                     input logic signed [11:0] bs,
                                     input logic signed [11:0] py,
                                     input logic signed [11:0] ps);
        return ((by + bs) >= py) && (by <= (py + ps));
    endfunction

endpackage

// File: rtl/edge_pulse.sv
// Two-flop sampler plus one history flop; emits a one-cycle pulse on the
// selected edge (FALLING=1: high->low, FALLING=0: low->high).
module edge_pulse #(
    parameter bit FALLING = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic pulse
);

    logic [2:0] sh;

    // Synchroniser chain: sh[1] is the synchronised level, sh[2] its previous value.
    always_ff @(posedge clk) begin
        if (reset) sh <= '0;
        else       sh <= {sh[1:0], din};
    end

    assign pulse = FALLING ? (sh[2] & ~sh[1]) : (~sh[2] & sh[1]);

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: frame-rate move strobes, miss detection, scoring and
// serve/point/game-over flow. Optional feature macro: AUTO_SERVE_EN (serve
// automatically SERVE_DELAY frames after a point).
module pong_game_ctrl #(
    parameter int WIN_SCORE    = 9,
    parameter int FRAME_DIV    = 1,
    parameter int SERVE_DELAY  = 60,
    parameter int RIGHT_BORDER = pong_pkg::RIGHT_BORDER
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               vSync,
    input  logic               serve,
    input  logic signed [10:0] ballX,
    input  logic signed [10:0] ballY,
    input  logic [8:0]         ballSize,
    input  logic signed [10:0] padLY,
    input  logic signed [10:0] padRY,
    input  logic [8:0]         padSize,
    output logic               ballEnable,
    output logic               padEnable,
    output logic               ballReset,
    output logic [3:0]         scoreL,
    output logic [3:0]         scoreR,
    output logic               gameOver,
    output logic [2:0]         state
);
    import pong_pkg::*;

    localparam logic signed [11:0] RB  = 12'(RIGHT_BORDER);
    localparam logic [3:0]         WIN = 4'(WIN_SCORE);
    localparam logic [3:0]         DIV_LAST = 4'(FRAME_DIV - 1);

    logic       frame_tick, press, move_tick, auto_go;
    logic [3:0] div_cnt;
    state_t     state_q, state_d;
    logic [3:0] score_l_q, score_r_q, score_l_d, score_r_d;
    logic       en_d;

    edge_pulse #(.FALLING(1'b1)) u_vsync (
        .clk(clk), .reset(reset), .din(vSync), .pulse(frame_tick)
    );

    edge_pulse #(.FALLING(1'b0)) u_serve (
        .clk(clk), .reset(reset), .din(serve), .pulse(press)
    );

    // Position arithmetic in 12-bit signed; sizes are unsigned magnitudes.
    logic signed [11:0] bx, by, bs, ply, pry, ps;
    logic               miss_l, miss_r;

    assign bx  = {ballX[10], ballX};
    assign by  = {ballY[10], ballY};
    assign bs  = {3'b000, ballSize};
    assign ply = {padLY[10], padLY};
    assign pry = {padRY[10], padRY};
    assign ps  = {3'b000, padSize};

    assign miss_l = (bx <= 12'sd0) && !overlap(by, bs, ply, ps);
    assign miss_r = ((bx + bs) >= RB) && !overlap(by, bs, pry, ps);

    assign move_tick = frame_tick && (div_cnt == 4'd0);

    // Frame divider: restarts on PLAY entry so the first move lands one frame after a serve.
    always_ff @(posedge clk) begin
        if (reset)
            div_cnt <= 4'd0;
        else if (state_q != ST_PLAY && state_d == ST_PLAY)
            div_cnt <= 4'd0;
        else if (frame_tick)
            div_cnt <= (div_cnt >= DIV_LAST) ? 4'd0 : div_cnt + 4'd1;
    end

`ifdef AUTO_SERVE_EN
    logic [7:0] dly_cnt;

    // Auto-serve countdown: loaded on POINT entry, counts frames down to zero.
    always_ff @(posedge clk) begin
        if (reset)
            dly_cnt <= 8'd0;
        else if (state_q != ST_POINT && state_d == ST_POINT)
            dly_cnt <= 8'(SERVE_DELAY);
        else if (state_q == ST_POINT && frame_tick && dly_cnt != 8'd0)
            dly_cnt <= dly_cnt - 8'd1;
    end

    assign auto_go = (dly_cnt == 8'd0);
`else
    assign auto_go = 1'b0;
`endif

    // Next-state, score update and move-strobe decision.
    always_comb begin
        state_d   = state_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
        en_d      = 1'b0;
        unique case (state_q)
            ST_IDLE:  if (press) state_d = ST_SERVE;
            ST_SERVE: state_d = ST_PLAY;
            ST_PLAY: begin
                if (move_tick) begin
                    // Left miss wins a simultaneous double miss.
                    if (miss_l) begin
                        score_r_d = sat_inc(score_r_q);
                        state_d   = ST_POINT;
                    end else if (miss_r) begin
                        score_l_d = sat_inc(score_l_q);
                        state_d   = ST_POINT;
                    end else begin
                        en_d = 1'b1;
                    end
                end
            end
            ST_POINT: begin
                if (score_l_q >= WIN || score_r_q >= WIN) state_d = ST_GAMEOVER;
                else if (press || auto_go)                state_d = ST_SERVE;
            end
            ST_GAMEOVER: begin
                if (press) begin
                    score_l_d = 4'd0;
                    score_r_d = 4'd0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, scores and registered strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            score_l_q  <= 4'd0;
            score_r_q  <= 4'd0;
            ballEnable <= 1'b0;
            padEnable  <= 1'b0;
            ballReset  <= 1'b0;
        end else begin
            state_q    <= state_d;
            score_l_q  <= score_l_d;
            score_r_q  <= score_r_d;
            ballEnable <= en_d;
            padEnable  <= en_d;
            ballReset  <= (state_d == ST_SERVE);
        end
    end

    assign scoreL   = score_l_q;
    assign scoreR   = score_r_q;
    assign gameOver = (state_q == ST_GAMEOVER);
    assign state    = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl: a frame-level model predicts events
// (move strobe, ball reload, score change, game over) with their cycle; a
// monitor pops and compares whenever the DUT shows one.
module tb_pong_game_ctrl;
    localparam int WIN = 9, DIV = 2, SDLY = 3, RB = 799;
`ifdef AUTO_SERVE_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif
    localparam int K_RST = 0, K_MV = 1, K_SC = 2, K_GO = 3;

    logic clk = 1'b0, reset = 1'b1, vSync = 1'b1, serve = 1'b0;
    logic signed [10:0] ballX = 11'sd400, ballY = 11'sd300, padLY = 11'sd100, padRY = 11'sd100;
    logic [8:0] ballSize = 9'd16, padSize = 9'd64;
    logic ballEnable, padEnable, ballReset, gameOver;
    logic [3:0] scoreL, scoreR;
    logic [2:0] state;

    pong_game_ctrl #(.WIN_SCORE(WIN), .FRAME_DIV(DIV), .SERVE_DELAY(SDLY), .RIGHT_BORDER(RB)) dut (
        .clk(clk), .reset(reset), .vSync(vSync), .serve(serve),
        .ballX(ballX), .ballY(ballY), .ballSize(ballSize),
        .padLY(padLY), .padRY(padRY), .padSize(padSize),
        .ballEnable(ballEnable), .padEnable(padEnable), .ballReset(ballReset),
        .scoreL(scoreL), .scoreR(scoreR), .gameOver(gameOver), .state(state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0, bad = 0, rst_seen = 0;

    typedef struct { int kind; int at; int l; int r; int st; } ev_t;
    ev_t q[$];

    // Reference model: 0 idle, 1 serve, 2 play, 3 point, 4 game over.
    int m_st = 0, m_l = 0, m_r = 0, m_idx = 0, m_dly = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic void push(input int k, input int at, input int st);
        ev_t e;
        e.kind = k; e.at = at; e.l = m_l; e.r = m_r; e.st = st;
        q.push_back(e);
    endfunction

    function automatic bit ovl(input int by, input int bs, input int py, input int ps);
        return (by + bs >= py) && (by <= py + ps);
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press();
        int c;
        @(posedge clk); #1;
        c = cyc;
        serve = 1'b1;
        if (m_st == 0 || m_st == 3) begin
            push(K_RST, c + 3, 1);
            m_st = 2; m_idx = 0;
        end else if (m_st == 4) begin
            m_l = 0; m_r = 0;
            push(K_SC, c + 3, 0);
            m_st = 0;
        end
        step(3);
        serve = 1'b0;
        step(8);
    endtask

    task automatic frame(input int bx, input int by, input int bs, input int pl, input int pr, input int ps);
        int c;
        bit ml, mr;
        @(posedge clk); #1;
        c = cyc;
        ballX = 11'(bx); ballY = 11'(by); ballSize = 9'(bs);
        padLY = 11'(pl); padRY = 11'(pr); padSize = 9'(ps);
        vSync = 1'b0;
        if (m_st == 2) begin
            if (m_idx % DIV == 0) begin
                ml = (bx <= 0) && !ovl(by, bs, pl, ps);
                mr = (bx + bs >= RB) && !ovl(by, bs, pr, ps);
                if (ml || mr) begin
                    if (ml) m_r = (m_r < 15) ? m_r + 1 : 15;
                    else    m_l = (m_l < 15) ? m_l + 1 : 15;
                    push(K_SC, c + 3, 3);
                    if (m_l >= WIN || m_r >= WIN) begin
                        push(K_GO, c + 4, 4);
                        m_st = 4;
                    end else begin
                        m_st = 3; m_dly = SDLY;
                    end
                end else begin
                    push(K_MV, c + 3, 2);
                end
            end
            m_idx++;
        end else if (m_st == 3 && AUTO) begin
            m_dly--;
            if (m_dly == 0) begin
                push(K_RST, c + 4, 1);
                m_st = 2; m_idx = 0;
            end
        end
        step(4);
        vSync = 1'b1;
        step(12);
    endtask

    task automatic neutral();
        frame(400, 300, 16, 100, 100, 64);
    endtask

    // Make the next frame a move tick when playing.
    task automatic align();
        if (m_st == 2 && m_idx % DIV != 0) neutral();
    endtask

    task automatic rand_frame();
        int bx, bs, cat;
        bs  = 4 + int'($urandom % 60);
        cat = int'($urandom % 4);
        if (cat == 0)      bx = -int'($urandom % 20);
        else if (cat == 1) bx = RB - bs + int'($urandom % 10);
        else               bx = 50 + int'($urandom % 600);
        frame(bx, int'($urandom % 600), bs, int'($urandom % 600) - 50,
              int'($urandom % 600) - 50, 20 + int'($urandom % 100));
    endtask

    // Pop the next predicted event and compare it with what the DUT shows.
    task automatic sb_check(input int k);
        ev_t e;
        total++;
        if (q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event: kind %0d at cycle %0d, nothing predicted", k, cyc);
            return;
        end
        e = q.pop_front();
        if (e.kind != k || e.at != cyc || int'(state) != e.st ||
            (k == K_SC && (int'(scoreL) != e.l || int'(scoreR) != e.r)) ||
            (k == K_MV && !(ballEnable && padEnable))) begin
            bad++;
            $display("FAIL event: got kind %0d cyc %0d st %0d L %0d R %0d be %0d pe %0d; want kind %0d cyc %0d st %0d L %0d R %0d",
                     k, cyc, state, scoreL, scoreR, ballEnable, padEnable, e.kind, e.at, e.st, e.l, e.r);
        end
    endtask

    logic [3:0] pl_s = 4'd0, pr_s = 4'd0;
    logic       pg_s = 1'b0;

    // Monitor: one compare per observed DUT event.
    always @(negedge clk) begin
        if (!reset) begin
            if (ballReset) begin rst_seen++; sb_check(K_RST); end
            if (ballEnable || padEnable) sb_check(K_MV);
            if (scoreL != pl_s || scoreR != pr_s) sb_check(K_SC);
            if (gameOver && !pg_s) sb_check(K_GO);
        end
        pl_s = scoreL; pr_s = scoreR; pg_s = gameOver;
    end

    initial begin
        int n;
        step(3);
        reset = 1'b0;
        step(1);
        chk("rst_state", state, 0);
        chk("rst_scoreL", scoreL, 0);
        chk("rst_scoreR", scoreR, 0);
        chk("rst_ballEnable", ballEnable, 0);
        chk("rst_ballReset", ballReset, 0);
        chk("rst_gameOver", gameOver, 0);

        repeat (3) neutral();
        chk("idle_state", state, 0);

        // Serve, an ignored press during play, then steady play.
        press();
        press();
        repeat (4) neutral();

        // Left miss.
        align();
        frame(0, 300, 16, 100, 100, 64);
        chk("lmiss_state", state, 3);
        chk("lmiss_scoreR", scoreR, 1);

        // Ten frames in POINT with no button.
        n = rst_seen;
        repeat (10) neutral();
        chk("auto_serve_count", rst_seen - n, AUTO ? 1 : 0);
        if (m_st != 2) press();

        // Paddle return.
        align();
        frame(0, 120, 16, 100, 100, 64);
        chk("return_scoreR", scoreR, 1);

        // Random play.
        for (int i = 0; i < 80; i++) begin
            if (m_st == 2) rand_frame();
            else if (m_st == 3 && AUTO && ($urandom % 2 == 1)) rand_frame();
            else press();
        end

        // Drive right misses until the game ends.
        for (int i = 0; i < 80 && m_st != 4; i++) begin
            if (m_st == 2) frame(790, 500, 20, 0, 0, 10);
            else press();
        end
        chk("go_gameOver", gameOver, 1);
        chk("go_state", state, 4);
        chk("go_win_reached", int'(scoreL >= 4'(WIN) || scoreR >= 4'(WIN)), 1);
        press();
        chk("clear_state", state, 0);
        chk("clear_scoreL", scoreL, 0);
        chk("clear_scoreR", scoreR, 0);

        // Reset in the middle of play.
        press();
        neutral();
        frame(0, 300, 16, 100, 100, 64);
        @(posedge clk); #1;
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        m_st = 0; m_l = 0; m_r = 0;
        step(1);
        chk("midrst_state", state, 0);
        chk("midrst_scoreL", scoreL, 0);
        chk("midrst_scoreR", scoreR, 0);
        repeat (2) neutral();

        step(5);
        chk("events_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
